uart_word_tx: RTL and testbench

- Upstream feeder for the UART byte transmitter; sits between the tracer result path and uart_tx.
- Accepts 32-bit result words on a valid/ready interface and buffers them in a FIFO.
- Serialises each word into bytes, LSB first, and drives the transmitter's start_write/write_avl/write_data handshake.
- Guarantees exactly one start pulse per byte and never overruns the transmitter.

---
 rtl/uart_word_tx.sv | 186 ++++++++++++++++++
 tb/tb_uart_word_tx.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_tx.sv
// uart_word_tx: buffers 32-bit result words in a FIFO and feeds them LSB byte first to uart_tx.
// Optional feature macro UART_WORD_TX_CKSUM_EN appends a per-word XOR checksum byte.
module uart_word_tx #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned WORD_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*WORD_BYTES-1:0] in_data,
    output logic                    tx_start,
    input  logic                    tx_avl,
    output logic [7:0]              tx_data,
    output logic [DEPTH_LOG2:0]     fifo_count,
    output logic                    busy
);

    localparam int unsigned DATA_W = 8 * WORD_BYTES;
    localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W  = DEPTH_LOG2 + 1;
    localparam int unsigned IDX_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
`ifdef UART_WORD_TX_CKSUM_EN
        WAIT_DONE,
        CKSUM
`else
        WAIT_DONE
`endif
    } state_t;

    state_t                state, state_d;
    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DATA_W-1:0]     head_c;
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count_d;
    logic                  push_c, pop_c;
    logic [DATA_W-1:0]     sh, sh_d, sh_nxt;
    logic [IDX_W-1:0]      byte_idx, idx_d;
    logic [7:0]            tx_data_d;
    logic                  tx_start_d;
    logic                  busy_d;
`ifdef UART_WORD_TX_CKSUM_EN
    logic [7:0]            acc, acc_d;
    logic                  ck_phase, ck_phase_d;
`endif

    assign push_c = in_valid && in_ready;
    assign head_c = mem[rd_ptr];

    // Occupancy update; a simultaneous push and pop cancels out.
    always_comb begin
        count_d = fifo_count;
        case ({push_c, pop_c})
            2'b10:   count_d = fifo_count + CNT_W'(1);
            2'b01:   count_d = fifo_count - CNT_W'(1);
            default: count_d = fifo_count;
        endcase
    end

    // Word storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Next-state and datapath decode.
    always_comb begin
        state_d    = state;
        pop_c      = 1'b0;
        sh_d       = sh;
        sh_nxt     = sh >> 8;
        idx_d      = byte_idx;
        tx_data_d  = tx_data;
        tx_start_d = 1'b0;
`ifdef UART_WORD_TX_CKSUM_EN
        acc_d      = acc;
        ck_phase_d = ck_phase;
`endif
        case (state)
            IDLE: begin
                if (fifo_count != '0) begin
                    pop_c     = 1'b1;
                    sh_d      = head_c;
                    idx_d     = '0;
                    tx_data_d = head_c[7:0];
                    state_d   = ISSUE;
`ifdef UART_WORD_TX_CKSUM_EN
                    acc_d      = '0;
                    ck_phase_d = 1'b0;
`endif
                end
            end
            ISSUE: begin
                if (tx_avl) begin
                    tx_start_d = 1'b1;
                    state_d    = WAIT_ACK;
`ifdef UART_WORD_TX_CKSUM_EN
                    if (!ck_phase) begin
                        acc_d = acc ^ tx_data;
                    end
`endif
                end
            end
            // Only a low write_avl proves the byte was taken; never re-pulse.
            WAIT_ACK: begin
                if (!tx_avl) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tx_avl) begin
`ifdef UART_WORD_TX_CKSUM_EN
                    if (ck_phase) begin
                        state_d = IDLE;
                    end else if (byte_idx == IDX_W'(WORD_BYTES - 1)) begin
                        state_d = CKSUM;
                    end else begin
`else
                    if (byte_idx == IDX_W'(WORD_BYTES - 1)) begin
                        state_d = IDLE;
                    end else begin
`endif
                        idx_d     = byte_idx + IDX_W'(1);
                        sh_d      = sh_nxt;
                        tx_data_d = sh_nxt[7:0];
                        state_d   = ISSUE;
                    end
                end
            end
`ifdef UART_WORD_TX_CKSUM_EN
            CKSUM: begin
                tx_data_d  = acc;
                ck_phase_d = 1'b1;
                state_d    = ISSUE;
            end
`endif
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE) || (count_d != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            tx_start   <= 1'b0;
            tx_data    <= '0;
            sh         <= '0;
            byte_idx   <= '0;
`ifdef UART_WORD_TX_CKSUM_EN
            acc        <= '0;
            ck_phase   <= 1'b0;
`endif
        end else begin
            state      <= state_d;
            fifo_count <= count_d;
            in_ready   <= (count_d != CNT_W'(DEPTH));
            busy       <= busy_d;
            tx_start   <= tx_start_d;
            tx_data    <= tx_data_d;
            sh         <= sh_d;
            byte_idx   <= idx_d;
`ifdef UART_WORD_TX_CKSUM_EN
            acc        <= acc_d;
            ck_phase   <= ck_phase_d;
`endif
            if (push_c) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_word_tx.sv
// tb_uart_word_tx: directed + randomized bench for uart_word_tx with a uart_tx BFM
// and a byte-queue reference model of the framed output stream.
module tb_uart_word_tx;

    localparam int unsigned WB = 4;
`ifdef UART_WORD_TX_CKSUM_EN
    localparam int unsigned FB = WB + 1;
`else
    localparam int unsigned FB = WB;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        tx_start;
    logic        tx_avl;
    logic [7:0]  tx_data;
    logic [4:0]  fifo_count;
    logic        busy;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  rx_log[$];
    int unsigned starts     = 0;
    int unsigned bytes_done = 0;
    bit          stall      = 1'b0;
    bit          rand_bfm   = 1'b0;
    bit          bfm_busy   = 1'b0;
    int unsigned ack_hold   = 0;

    uart_word_tx #(.DEPTH_LOG2(4), .WORD_BYTES(WB)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .tx_start  (tx_start),
        .tx_avl    (tx_avl),
        .tx_data   (tx_data),
        .fifo_count(fifo_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference: a word becomes its bytes LSB first, optionally followed by their XOR.
    task automatic model_push(input logic [31:0] w);
        for (int i = 0; i < int'(WB); i++) begin
            exp_q.push_back(w[8*i +: 8]);
        end
`ifdef UART_WORD_TX_CKSUM_EN
        exp_q.push_back(w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24]);
`endif
    endtask

    // uart_tx stand-in: takes a byte on start, optionally holds write_avl high, then is busy.
    initial begin : bfm
        logic [7:0]  held;
        int unsigned hold_left;
        int unsigned busy_left;
        held = '0;
        hold_left = 0;
        busy_left = 0;
        tx_avl = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                chk("start_gate", 32'(bfm_busy || (tx_avl !== 1'b1)), 32'(0));
                chk("byte_expected", 32'(exp_q.size() != 0), 32'(1));
                if (exp_q.size() != 0) begin
                    chk("byte_value", 32'(tx_data), 32'(exp_q.pop_front()));
                end
                rx_log.push_back(tx_data);
                starts++;
                held      = tx_data;
                bfm_busy  = 1'b1;
                hold_left = rand_bfm ? $urandom_range(0, 2) : ack_hold;
                busy_left = rand_bfm ? $urandom_range(1, 12) : 10;
                if (hold_left == 0) tx_avl = 1'b0;
            end else if (bfm_busy) begin
                if (!reset) chk("tx_data_stable", 32'(tx_data), 32'(held));
                if (tx_avl) begin
                    hold_left--;
                    if (hold_left == 0) tx_avl = 1'b0;
                end else begin
                    busy_left--;
                    if (busy_left == 0) begin
                        tx_avl     = 1'b1;
                        bfm_busy   = 1'b0;
                        bytes_done++;
                    end
                end
            end else begin
                tx_avl = !stall;
            end
        end
    end

    // Called at a negedge; holds the word until accepted, returns at the following negedge.
    task automatic push_word(input logic [31:0] w);
        int unsigned t = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (in_ready !== 1'b1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (in_ready !== 1'b1) chk("push_timeout", 32'(in_ready), 32'(1));
        @(posedge clk);
        if (in_ready === 1'b1) model_push(w);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int unsigned t = 0;
        while (busy !== 1'b0 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk(tag, 32'(busy), 32'(0));
        chk({tag, "_queue"}, 32'(exp_q.size()), 32'(0));
    endtask

    // Returns at the posedge where the DUT first samples write_avl high after the target byte.
    task automatic wait_bytes_done(input int unsigned target);
        int unsigned t = 0;
        while (bytes_done < target && t < 5000) begin
            @(posedge clk);
            t++;
        end
        chk("bytes_done_wait", 32'(bytes_done >= target), 32'(1));
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [31:0] w;
        int unsigned s0;
        int unsigned base;
        int unsigned n;
        int unsigned t;

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_tx_start", 32'(tx_start), 32'(0));
        chk("rst_tx_data", 32'(tx_data), 32'(0));
        chk("rst_fifo_count", 32'(fifo_count), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        reset = 1'b0;
        @(negedge clk);

        // Single word with latency and byte order checks.
        rx_log.delete();
        s0 = starts;
        in_valid = 1'b1;
        in_data  = 32'hA1B2C3D4;
        @(posedge clk);
        model_push(32'hA1B2C3D4);
        @(negedge clk);
        in_valid = 1'b0;
        chk("lat_count_after_push", 32'(fifo_count), 32'(1));
        chk("lat_busy", 32'(busy), 32'(1));
        @(negedge clk);
        chk("lat_start_e1", 32'(tx_start), 32'(0));
        chk("lat_count_after_pop", 32'(fifo_count), 32'(0));
        @(negedge clk);
        chk("lat_start_e2", 32'(tx_start), 32'(1));
        wait_idle("single_idle");
        chk("single_starts", 32'(starts - s0), 32'(FB));
        chk("single_b0", 32'(rx_log[0]), 32'hD4);
        chk("single_b1", 32'(rx_log[1]), 32'hC3);
        chk("single_b2", 32'(rx_log[2]), 32'hB2);
        chk("single_b3", 32'(rx_log[3]), 32'hA1);
`ifdef UART_WORD_TX_CKSUM_EN
        chk("single_cksum", 32'(rx_log[4]), 32'h04);
`endif

        // Slow ack: write_avl stays high 5 cycles after each start.
        ack_hold = 5;
        s0 = starts;
        push_word($urandom);
        wait_idle("slow_ack_idle");
        chk("slow_ack_starts", 32'(starts - s0), 32'(FB));
        ack_hold = 0;

        // Stalled transmitter: one word parked in the FSM, then fill the FIFO.
        stall = 1'b1;
        @(negedge clk);
        @(negedge clk);
        push_word($urandom);
        repeat (3) @(negedge clk);
        chk("stall_count0", 32'(fifo_count), 32'(0));
        for (int i = 0; i < 16; i++) push_word($urandom);
        chk("full_count", 32'(fifo_count), 32'(16));
        chk("full_ready", 32'(in_ready), 32'(0));
        in_valid = 1'b1;
        in_data  = $urandom;
        repeat (3) begin
            @(negedge clk);
            chk("full_hold_ready", 32'(in_ready), 32'(0));
        end
        chk("full_hold_count", 32'(fifo_count), 32'(16));
        in_valid = 1'b0;

        // Push offered at full in the pop cycle must be refused.
        base  = bytes_done;
        stall = 1'b0;
        wait_bytes_done(base + FB);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = $urandom;
        chk("fullpop_ready", 32'(in_ready), 32'(0));
        @(negedge clk);
        in_valid = 1'b0;
        chk("fullpop_count", 32'(fifo_count), 32'(15));
        push_word($urandom);
        chk("refill_count", 32'(fifo_count), 32'(16));
        wait_idle("drain_full");

        // Simultaneous push and pop at count 5.
        stall = 1'b1;
        @(negedge clk);
        @(negedge clk);
        push_word($urandom);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) push_word($urandom);
        chk("five_count", 32'(fifo_count), 32'(5));
        base  = bytes_done;
        stall = 1'b0;
        wait_bytes_done(base + FB);
        @(negedge clk);
        w = $urandom;
        in_valid = 1'b1;
        in_data  = w;
        chk("pushpop_ready", 32'(in_ready), 32'(1));
        @(posedge clk);
        model_push(w);
        @(negedge clk);
        in_valid = 1'b0;
        chk("pushpop_count", 32'(fifo_count), 32'(5));
        wait_idle("pushpop_idle");

        // Reset while byte 2 of 0x11223344 is being issued with 3 words queued.
        stall = 1'b1;
        @(negedge clk);
        @(negedge clk);
        push_word(32'h11223344);
        for (int i = 0; i < 3; i++) push_word($urandom);
        repeat (2) @(negedge clk);
        chk("mid_queued", 32'(fifo_count), 32'(3));
        s0    = starts;
        stall = 1'b0;
        n = 0;
        t = 0;
        while (n < 2 && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
            if (tx_start === 1'b1) n++;
        end
        chk("mid_reach_byte2", 32'(n), 32'(2));
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk("mid_rst_start", 32'(tx_start), 32'(0));
        chk("mid_rst_count", 32'(fifo_count), 32'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("mid_post_busy", 32'(busy), 32'(0));
        chk("mid_post_ready", 32'(in_ready), 32'(1));
        chk("mid_post_starts", 32'(starts - s0), 32'(1));

        // Pointer wrap: 40 incrementing words, random transmitter timing and upstream gaps.
        rand_bfm = 1'b1;
        s0 = starts;
        w  = $urandom;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            push_word(w + 32'(i));
        end
        wait_idle("wrap_idle");
        chk("wrap_bytes", 32'(starts - s0), 32'(40 * FB));
        chk("wrap_count", 32'(fifo_count), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
